// File: rtl/lc3_decode_queue.sv
// LC-3 decode stage: a small instruction FIFO between Fetch and Execute feeding a registered
// decode output stage, plus condition codes (PSR), branch evaluation and an illegal-opcode counter.
module lc3_decode_queue #(
    parameter int IQ_DEPTH    = 2,
    parameter int PSR_BYPASS  = 1,
    parameter int BADOP_CNT_W = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [15:0]            instr_in,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic                   flush,
    input  logic [15:0]            VSR1,
    input  logic [15:0]            VSR2,
    input  logic                   psr_we,
    input  logic [15:0]            DR_in,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [2:0]             sr1,
    output logic [2:0]             sr2,
    output logic [2:0]             dr,
    output logic [5:0]             E_Control,
    output logic [5:0]             C_Control,
    output logic [1:0]             W_Control,
    output logic                   M_Control,
    output logic                   F_Control,
    output logic [47:0]            D_Data,
    output logic [2:0]             psr,
    output logic                   badop,
    output logic [BADOP_CNT_W-1:0] badop_count
);
    localparam int            PW   = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam logic [PW:0]   FULL = (PW+1)'(IQ_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(IQ_DEPTH - 1);

    // Handshakes: a word moves only on a cycle where its valid and ready are both high;
    // a producer holding valid keeps its data stable until the transfer happens.
    logic [15:0]   iq_mem [IQ_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   iq_count;
    logic [15:0]   ir, head;
    logic          push, pop;
    logic [2:0]    psr_new, psr_eff;

    logic [5:0] d_e, d_c;
    logic [1:0] d_w;
    logic       d_m, d_f, d_bad;
    logic [2:0] d_sr1, d_sr2, d_dr;

    assign instr_ready = !reset && !flush && (iq_count < FULL);
    assign push        = instr_valid && instr_ready;
    assign pop         = (iq_count != '0) && (!dec_valid || dec_ready);
    assign head        = iq_mem[rd_ptr];
    assign psr_new     = DR_in[15] ? 3'b100 : ((|DR_in) ? 3'b001 : 3'b010);
    assign psr_eff     = ((PSR_BYPASS != 0) && psr_we) ? psr_new : psr;
    assign D_Data      = {ir, VSR1, VSR2};

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            iq_count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            iq_count <= iq_count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) iq_mem[wr_ptr] <= instr_in;
    end

    always_ff @(posedge clock) begin
        if (reset)       psr <= 3'b010;
        else if (psr_we) psr <= psr_new;
    end

    always_comb begin
        d_e = '0; d_c = '0; d_w = '0; d_m = 1'b0; d_f = 1'b0; d_bad = 1'b0;
        d_sr1 = '0; d_sr2 = '0; d_dr = '0;
        d_c[5:4] = head[13] ? 2'b10 : (head[12] ? 2'b00 : 2'b01);
        case (head[15:12])
            4'b0001, 4'b0101: begin
                d_e = {1'b0, head[14], head[5], 3'b000};
                d_dr = head[11:9]; d_sr1 = head[8:6]; d_sr2 = head[2:0];
            end
            4'b1001: begin d_e = 6'b100000; d_dr = head[11:9]; d_sr1 = head[8:6]; end
            4'b0000: begin d_e = 6'b000011; d_f = |(head[11:9] & psr_eff); end
            4'b1100: begin d_e = 6'b000100; d_f = 1'b1; d_sr1 = head[8:6]; end
            4'b0100: begin
                d_e = head[11] ? 6'b000001 : 6'b000100;
                d_c[3:0] = 4'b1000; d_w = 2'b11; d_f = 1'b1; d_dr = 3'd7; d_sr1 = head[8:6];
            end
            4'b0010: begin d_e = 6'b000011; d_c[3:0] = 4'b0010; d_w = 2'b01; d_dr = head[11:9]; end
            4'b0110: begin
                d_e = 6'b000100; d_c[3:0] = 4'b0010; d_w = 2'b01;
                d_dr = head[11:9]; d_sr1 = head[8:6];
            end
            4'b1010: begin
                d_e = 6'b000011; d_c[3:0] = 4'b0001; d_w = 2'b01; d_m = 1'b1; d_dr = head[11:9];
            end
            4'b1110: begin d_e = 6'b000011; d_c[3:0] = 4'b0110; d_w = 2'b10; d_dr = head[11:9]; end
            4'b0011: begin d_e = 6'b000011; d_c[3:0] = 4'b0100; d_sr2 = head[11:9]; end
            4'b0111: begin
                d_e = 6'b000100; d_c[3:0] = 4'b0100; d_sr1 = head[8:6]; d_sr2 = head[11:9];
            end
            4'b1011: begin d_e = 6'b000011; d_m = 1'b1; d_sr2 = head[11:9]; end
            default: begin
                // 1000, 1101, 1111: no LC-3 meaning here, drive a recognisable all-ones pattern
                d_e = 6'b111111; d_c[3:0] = 4'b1111; d_w = 2'b11; d_f = 1'b1; d_m = 1'b1;
                d_sr1 = 3'd7; d_sr2 = 3'd7; d_dr = 3'd7; d_bad = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dec_valid <= 1'b0; ir <= '0;
            E_Control <= '0; C_Control <= '0; W_Control <= '0; M_Control <= 1'b0; F_Control <= 1'b0;
            sr1 <= '0; sr2 <= '0; dr <= '0;
            badop <= 1'b0; badop_count <= '0;
        end else if (flush) begin
            dec_valid <= 1'b0;
            badop     <= 1'b0;
        end else if (pop) begin
            dec_valid <= 1'b1; ir <= head;
            E_Control <= d_e; C_Control <= d_c; W_Control <= d_w; M_Control <= d_m; F_Control <= d_f;
            sr1 <= d_sr1; sr2 <= d_sr2; dr <= d_dr;
            badop <= d_bad;
            if (d_bad && (badop_count != '1)) badop_count <= badop_count + 1'b1;
        end else begin
            badop <= 1'b0;
            if (dec_valid && dec_ready) dec_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lc3_decode_queue.sv
// Bench for lc3_decode_queue: scoreboarded stream checks on a bypassing and a non-bypassing
// instance driven by the same inputs, plus directed latency, hold, flush, PSR and counter cases.
module tb_lc3_decode_queue;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, instr_valid, flush, psr_we, dec_ready;
    logic [15:0] instr_in, VSR1, VSR2, DR_in;

    logic        instr_ready, dec_valid, M_Control, F_Control, badop;
    logic [2:0]  sr1, sr2, dr, psr;
    logic [5:0]  E_Control, C_Control;
    logic [1:0]  W_Control;
    logic [47:0] D_Data;
    logic [7:0]  badop_count;

    logic        nb_instr_ready, nb_dec_valid, nb_M_Control, nb_F_Control, nb_badop;
    logic [2:0]  nb_sr1, nb_sr2, nb_dr, nb_psr;
    logic [5:0]  nb_E_Control, nb_C_Control;
    logic [1:0]  nb_W_Control;
    logic [47:0] nb_D_Data;
    logic [7:0]  nb_badop_count;

    lc3_decode_queue #(.IQ_DEPTH(2), .PSR_BYPASS(1), .BADOP_CNT_W(8)) dut (
        .clock(clock), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .flush(flush), .VSR1(VSR1), .VSR2(VSR2), .psr_we(psr_we),
        .DR_in(DR_in), .dec_valid(dec_valid), .dec_ready(dec_ready), .sr1(sr1), .sr2(sr2), .dr(dr),
        .E_Control(E_Control), .C_Control(C_Control), .W_Control(W_Control),
        .M_Control(M_Control), .F_Control(F_Control), .D_Data(D_Data), .psr(psr),
        .badop(badop), .badop_count(badop_count));

    lc3_decode_queue #(.IQ_DEPTH(2), .PSR_BYPASS(0), .BADOP_CNT_W(8)) dut_nb (
        .clock(clock), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(nb_instr_ready), .flush(flush), .VSR1(VSR1), .VSR2(VSR2), .psr_we(psr_we),
        .DR_in(DR_in), .dec_valid(nb_dec_valid), .dec_ready(dec_ready), .sr1(nb_sr1),
        .sr2(nb_sr2), .dr(nb_dr), .E_Control(nb_E_Control), .C_Control(nb_C_Control),
        .W_Control(nb_W_Control), .M_Control(nb_M_Control), .F_Control(nb_F_Control),
        .D_Data(nb_D_Data), .psr(nb_psr), .badop(nb_badop), .badop_count(nb_badop_count));

    int n_tests = 0;
    int n_fail  = 0;
    int exp_bad = 0;
    int n_badop = 0;
    int n_badop_nb = 0;
    logic [2:0]  psr_load_byp, psr_load_nb;
    // entry: {expected pack (bypass), expected F (no bypass), IR}
    logic [41:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pack = {E[24:19], C[18:13], W[12:11], M[10], F[9], sr1[8:6], sr2[5:3], dr[2:0]}
    function automatic logic [24:0] model(input logic [15:0] ir, input logic [2:0] p);
        logic [5:0] e, c;
        logic [1:0] w;
        logic       m, f;
        logic [2:0] s1, s2, d;
        e = '0; c = '0; w = '0; m = 0; f = 0; s1 = '0; s2 = '0; d = '0;
        case (ir[13:12])
            2'b01:   c[5:4] = 2'b00;
            2'b00:   c[5:4] = 2'b01;
            default: c[5:4] = 2'b10;
        endcase
        case (ir[15:12])
            4'h1: begin e = {2'b00, ir[5], 3'b000}; d = ir[11:9]; s1 = ir[8:6]; s2 = ir[2:0]; end
            4'h5: begin e = {2'b01, ir[5], 3'b000}; d = ir[11:9]; s1 = ir[8:6]; s2 = ir[2:0]; end
            4'h9: begin e = 6'b100000; d = ir[11:9]; s1 = ir[8:6]; end
            4'h0: begin e = 6'b000011; f = |(ir[11:9] & p); end
            4'hC: begin e = 6'b000100; f = 1; s1 = ir[8:6]; end
            4'h4: begin e = ir[11] ? 6'd1 : 6'd4; c[3:0] = 4'b1000; w = 3; f = 1; d = 7; s1 = ir[8:6]; end
            4'h2: begin e = 6'd3; c[3:0] = 4'b0010; w = 1; d = ir[11:9]; end
            4'h6: begin e = 6'd4; c[3:0] = 4'b0010; w = 1; d = ir[11:9]; s1 = ir[8:6]; end
            4'hA: begin e = 6'd3; c[3:0] = 4'b0001; w = 1; m = 1; d = ir[11:9]; end
            4'hE: begin e = 6'd3; c[3:0] = 4'b0110; w = 2; d = ir[11:9]; end
            4'h3: begin e = 6'd3; c[3:0] = 4'b0100; s2 = ir[11:9]; end
            4'h7: begin e = 6'd4; c[3:0] = 4'b0100; s1 = ir[8:6]; s2 = ir[11:9]; end
            4'hB: begin e = 6'd3; m = 1; s2 = ir[11:9]; end
            default: begin e = 6'h3F; c[3:0] = 4'hF; w = 3; f = 1; m = 1; s1 = 7; s2 = 7; d = 7; end
        endcase
        return {e, c, w, m, f, s1, s2, d};
    endfunction

    task automatic consume();
        logic [41:0] e;
        logic [24:0] p;
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check_eq("dec", {E_Control, C_Control, W_Control, M_Control, F_Control, sr1, sr2, dr},
                     e[41:17]);
            check_eq("d_data", D_Data, {e[15:0], VSR1, VSR2});
            p = e[41:17];
            p[9] = e[16];
            check_eq("dec_nb", {nb_E_Control, nb_C_Control, nb_W_Control, nb_M_Control,
                     nb_F_Control, nb_sr1, nb_sr2, nb_dr}, p);
            check_eq("d_data_nb", nb_D_Data, {e[15:0], VSR1, VSR2});
        end
    endtask

    task automatic tick();
        logic [24:0] pb, pn;
        #1;
        if (instr_valid && instr_ready) begin
            pb = model(instr_in, psr_load_byp);
            pn = model(instr_in, psr_load_nb);
            exp_q.push_back({pb, pn[9], instr_in});
            if (instr_in[15:12] == 4'h8 || instr_in[15:12] == 4'hD || instr_in[15:12] == 4'hF)
                exp_bad++;
        end
        if (dec_valid && dec_ready) consume();
        @(posedge clock);
        #1;
        if (badop) n_badop++;
        if (nb_badop) n_badop_nb++;
    endtask

    task automatic drain();
        int t;
        t = 0;
        dec_ready = 1; instr_valid = 0;
        while ((exp_q.size() != 0 || dec_valid) && t < 50) begin
            tick();
            t++;
        end
        check_eq("drain_done", (exp_q.size() == 0) && !dec_valid, 1);
    endtask

    task automatic push_word(input logic [15:0] w);
        instr_in = w; instr_valid = 1;
        tick();
        instr_valid = 0;
    endtask

    initial begin
        logic [15:0] words[4];
        int pushed, guard;
        words[0] = 16'h5A3F; words[1] = 16'h927F; words[2] = 16'h2E05; words[3] = 16'hE3FF;
        reset = 1; instr_valid = 0; flush = 0; psr_we = 0; dec_ready = 0;
        instr_in = 0; VSR1 = 16'h1234; VSR2 = 16'hABCD; DR_in = 0;
        psr_load_byp = 3'b010; psr_load_nb = 3'b010;

        tick(); tick();
        check_eq("ready_in_reset", instr_ready, 0);
        reset = 0;
        tick();
        check_eq("rst_dec_valid", dec_valid, 0);
        check_eq("rst_psr", psr, 3'b010);
        check_eq("rst_badop", {badop, badop_count}, 0);
        check_eq("rst_outputs", {E_Control, C_Control, W_Control, M_Control, F_Control,
                 sr1, sr2, dr, D_Data[47:32]}, 0);

        // first-word latency
        dec_ready = 1;
        push_word(16'h1261);
        check_eq("lat_k_valid", dec_valid, 0);
        tick();
        check_eq("lat_k1_valid", dec_valid, 1);
        check_eq("add_e", E_Control, 6'b001000);
        check_eq("add_regs", {dr, sr1, C_Control}, {3'd1, 3'd1, 6'd0});
        drain();

        // PSR encoding
        psr_we = 1;
        DR_in = 16'h0000; tick(); check_eq("psr_zero", psr, 3'b010);
        DR_in = 16'h8000; tick(); check_eq("psr_neg", psr, 3'b100);
        DR_in = 16'h0005; tick(); check_eq("psr_pos", psr, 3'b001);
        psr_we = 0;
        psr_load_byp = 3'b001; psr_load_nb = 3'b001;

        // random stream, stable PSR
        n_badop = 0; n_badop_nb = 0;
        for (int i = 0; i < 200; i++) begin
            instr_valid = 1'($urandom_range(0, 1));
            instr_in    = 16'($urandom);
            dec_ready   = 1'($urandom_range(0, 1));
            VSR1 = 16'($urandom); VSR2 = 16'($urandom);
            tick();
        end
        drain();
        check_eq("rand_badop_pulses", n_badop, exp_bad);
        check_eq("rand_badop_pulses_nb", n_badop_nb, exp_bad);
        check_eq("rand_badop_count", badop_count, (exp_bad > 255) ? 255 : exp_bad);
        check_eq("rand_badop_count_nb", nb_badop_count, (exp_bad > 255) ? 255 : exp_bad);

        // backpressure: output holds first word, queue fills, order preserved
        dec_ready = 0;
        for (int i = 0; i < 4; i++) begin
            instr_in = words[i]; instr_valid = 1;
            #1;
            check_eq($sformatf("hold_ready_%0d", i), instr_ready, (i < 3) ? 1 : 0);
            check_eq($sformatf("hold_ready_nb_%0d", i), nb_instr_ready, (i < 3) ? 1 : 0);
            tick();
        end
        instr_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_ir", {dec_valid, D_Data[47:32]}, {1'b1, words[0]});
        end
        drain();

        // flush with a full queue and a word offered
        dec_ready = 0;
        for (int i = 0; i < 3; i++) push_word(words[i]);
        flush = 1; instr_valid = 1; instr_in = 16'h1FFF;
        #1;
        check_eq("flush_ready", instr_ready, 0);
        tick();
        exp_q.delete();
        flush = 0; instr_valid = 0;
        check_eq("flush_dec_valid", {dec_valid, nb_dec_valid, badop}, 0);
        check_eq("flush_psr_kept", psr, 3'b001);
        dec_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("flush_empty", dec_valid, 0);
        end

        // BR loading in the same cycle as a PSR write
        psr_load_byp = 3'b100; psr_load_nb = 3'b001;
        push_word(16'h0800);
        psr_we = 1; DR_in = 16'h8000;
        tick();
        psr_we = 0;
        check_eq("br_f_bypass", F_Control, 1);
        check_eq("br_f_nobypass", nb_F_Control, 0);
        drain();
        psr_load_byp = 3'b100; psr_load_nb = 3'b100;

        // 300 illegal opcodes: pulses counted, counter saturates
        n_badop = 0; n_badop_nb = 0; pushed = 0; guard = 0;
        dec_ready = 1;
        while (pushed < 300 && guard < 1000) begin
            instr_in = 16'hD000; instr_valid = 1;
            #1;
            if (instr_ready) pushed++;
            tick();
            guard++;
        end
        check_eq("illegal_pushed", pushed, 300);
        drain();
        check_eq("illegal_pulses", n_badop, 300);
        check_eq("illegal_pulses_nb", n_badop_nb, 300);
        check_eq("illegal_sat", badop_count, 8'd255);
        check_eq("illegal_sat_nb", nb_badop_count, 8'd255);

        // reset mid-stream
        dec_ready = 0;
        push_word(16'h1261); push_word(16'h5A3F); push_word(16'hD000);
        reset = 1;
        tick();
        exp_q.delete();
        check_eq("mid_rst_ready", instr_ready, 0);
        check_eq("mid_rst_state", {psr, dec_valid, badop_count}, {3'b010, 1'b0, 8'd0});
        check_eq("mid_rst_state_nb", {nb_psr, nb_dec_valid, nb_badop_count}, {3'b010, 1'b0, 8'd0});
        reset = 0;
        tick();
        check_eq("post_rst_ready", instr_ready, 1);
        check_eq("post_rst_empty", dec_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
